// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
//   Shared types and constants for the VRAM arbiter slice.
//   - cpu_state_t : CPU access FSM states
//   - tag_t       : owner tag carried down the VRAM issue pipeline
//   - FB_W/FB_H   : nominal framebuffer dimensions
//   - BLANK_COLOR_DEF : default colour driven outside the visible area
//   - disp_key()  : forms the display VRAM address from pixel coordinates
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RD1  = 2'd1,
    C_RD2  = 2'd2,
    C_ACK  = 2'd3
  } cpu_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  localparam int FB_W = 200;
  localparam int FB_H = 150;

  localparam logic [7:0] BLANK_COLOR_DEF = 8'h00;

  // Display address is simply the row/column pair, row in the upper byte.
  function automatic logic [15:0] disp_key(input logic [7:0] v, input logic [7:0] h);
    return {v, h};
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
//   CPU MMIO request/acknowledge bus into the VRAM arbiter.
//   master (CPU side)     : drives cpu_req, cpu_we, cpu_addr, cpu_wdata
//   slave  (arbiter side) : drives cpu_rdata, cpu_ack
//   cpu_req and the command fields are held stable until cpu_ack pulses.
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );

endinterface

// File: rtl/vram_issue_pipe.sv
// -----------------------------------------------------------------------------
// vram_issue_pipe
//   Two-stage tag/valid shift register tracking who owns each VRAM access.
//   Stage 1 loads on the issue edge, stage 2 one edge later, so cap_tag names
//   the owner of the data currently on vram_rdata.
//   Ports: clk, rst (async, active high), issue_tag (in), cap_tag (out).
// -----------------------------------------------------------------------------
module vram_issue_pipe
  import vram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  tag_t issue_tag,
  output tag_t cap_tag
);

  tag_t s1_tag_reg;
  tag_t s2_tag_reg;
  logic s1_valid_reg;
  logic s2_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_tag_reg   <= TAG_NONE;
      s2_tag_reg   <= TAG_NONE;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_tag_reg   <= issue_tag;
      s1_valid_reg <= (issue_tag != TAG_NONE);
      s2_tag_reg   <= s1_tag_reg;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  assign cap_tag = s2_valid_reg ? s2_tag_reg : TAG_NONE;

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Shares one synchronous single-port VRAM between VGA scan-out and CPU MMIO.
//   Display fetches always win the slot; CPU reads/writes take idle slots.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     disp_h, disp_v, disp_vis pixel coordinates and visible flag from timing gen
//     disp_color               registered pixel colour to the DAC path
//     cpu                      CPU request/ack bus (slave side)
//     vram_addr/we/wdata       registered VRAM command
//     vram_rdata               VRAM read data, valid the cycle after the address edge
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] BLANK_COLOR = DATA_W'(BLANK_COLOR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        disp_h,
  input  logic [7:0]        disp_v,
  input  logic              disp_vis,
  output logic [DATA_W-1:0] disp_color,
  vram_arbiter_if.slave     cpu,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  logic [ADDR_W-1:0] pix_key;
  logic [ADDR_W-1:0] last_key_reg;
  logic              disp_pending;
  logic              cpu_grant;
  tag_t              issue_tag;
  tag_t              cap_tag;
  cpu_state_t        state_reg;
  cpu_state_t        state_next;
  logic [DATA_W-1:0] cpu_rdata_reg;

  assign pix_key = ADDR_W'(disp_key(disp_v, disp_h));

  // A coordinate change is detected and issued in the same cycle: the display
  // owns every slot it asks for, so a pending fetch never has to wait. That is
  // what gives the 3-edge change-to-colour latency.
  assign disp_pending = disp_vis && (pix_key != last_key_reg);
  assign cpu_grant    = !disp_pending && (state_reg == C_IDLE) && cpu.cpu_req;

  always_comb begin
    issue_tag = TAG_NONE;
    if (disp_pending) begin
      issue_tag = TAG_DISP;
    end else if (cpu_grant) begin
      issue_tag = TAG_CPU;
    end
  end

  // Issue stage: at most one VRAM operation per edge. last_key resets to
  // all-ones so the first visible pixel always triggers a fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_addr    <= '0;
      vram_we      <= 1'b0;
      vram_wdata   <= '0;
      last_key_reg <= '1;
    end else begin
      vram_we <= 1'b0;
      if (disp_pending) begin
        vram_addr    <= pix_key;
        last_key_reg <= pix_key;
      end else if (cpu_grant) begin
        vram_addr  <= cpu.cpu_addr;
        vram_we    <= cpu.cpu_we;
        vram_wdata <= cpu.cpu_wdata;
      end
    end
  end

  vram_issue_pipe u_issue_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue_tag (issue_tag),
    .cap_tag   (cap_tag)
  );

  // Blanking overrides immediately; otherwise only display-owned data lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_color <= BLANK_COLOR;
    end else if (!disp_vis) begin
      disp_color <= BLANK_COLOR;
    end else if (cap_tag == TAG_DISP) begin
      disp_color <= vram_rdata;
    end
  end

  // CPU FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= C_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // CPU FSM: next state. Writes complete as soon as they are issued; reads
  // wait two edges for the RAM data to come back.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      C_IDLE:  if (cpu_grant) state_next = cpu.cpu_we ? C_ACK : C_RD1;
      C_RD1:   state_next = C_RD2;
      C_RD2:   state_next = C_ACK;
      C_ACK:   state_next = C_IDLE;
      default: state_next = C_IDLE;
    endcase
  end

  // CPU FSM: outputs
  always_comb begin
    cpu.cpu_ack = (state_reg == C_ACK);
  end

  // In C_RD2 vram_rdata holds the word addressed at the grant edge; a display
  // fetch issued in the meantime only reaches vram_rdata one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_reg <= '0;
    end else if (state_reg == C_RD2) begin
      cpu_rdata_reg <= vram_rdata;
    end
  end

  assign cpu.cpu_rdata = cpu_rdata_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter: directed reset, scan-out, blanking,
//   CPU write/readback and contention cases, then an abbreviated scan with
//   random CPU traffic compared against a memory model.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int SOAK_LINES    = 32;
  localparam int SOAK_LINE_LEN = 64;
  localparam int SOAK_VIS_W    = 48;

  logic        clk;
  logic        rst;
  logic [7:0]  disp_h;
  logic [7:0]  disp_v;
  logic        disp_vis;
  logic [7:0]  disp_color;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  vram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) cpu_if ();

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .BLANK_COLOR(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_h     (disp_h),
    .disp_v     (disp_v),
    .disp_vis   (disp_vis),
    .disp_color (disp_color),
    .cpu        (cpu_if),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int ack_count = 0;
  bit scan_done = 1'b0;

  logic [7:0] vram_mem [0:65535];
  logic [7:0] ref_mem  [0:65535];

  function automatic logic [7:0] pat(input int a);
    logic [15:0] av;
    av = a[15:0];
    if (av == 16'h0305) return 8'hA7;
    return av[7:0] ^ {av[11:8], av[15:12]} ^ 8'h3C;
  endfunction

  // Behavioural synchronous single-port VRAM, read-before-write.
  initial begin
    for (int i = 0; i < 65536; i++) vram_mem[i] = pat(i);
    forever begin
      @(posedge clk);
      vram_rdata <= vram_mem[vram_addr];
      if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    end
  end

  always @(posedge clk) begin
    if (cpu_if.cpu_ack) ack_count <= ack_count + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one CPU op; lat counts edges from request to the ack cycle.
  task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd);
    bit done;
    done = 1'b0;
    cpu_if.cpu_we    = we;
    cpu_if.cpu_addr  = addr;
    cpu_if.cpu_wdata = wd;
    cpu_if.cpu_req   = 1'b1;
    lat = 0;
    rd  = '0;
    while (!done && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (cpu_if.cpu_ack) begin
        done = 1'b1;
        rd   = cpu_if.cpu_rdata;
      end
    end
    if (!done) lat = 99;
    tick();
    cpu_if.cpu_req = 1'b0;
    $display("cpu %s addr=%04h wdata=%02h rdata=%02h lat=%0d", we ? "wr" : "rd", addr, wd, rd, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] rd;

    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    rst              = 1'b1;
    disp_h           = 8'd0;
    disp_v           = 8'd0;
    disp_vis         = 1'b0;
    cpu_if.cpu_req   = 1'b0;
    cpu_if.cpu_we    = 1'b0;
    cpu_if.cpu_addr  = 16'h0000;
    cpu_if.cpu_wdata = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_color", 32'(disp_color), 32'h00);
    check_val("rst_ack", 32'(cpu_if.cpu_ack), 32'h0);
    check_val("rst_rdata", 32'(cpu_if.cpu_rdata), 32'h00);
    check_val("rst_we", 32'(vram_we), 32'h0);
    check_val("rst_addr", 32'(vram_addr), 32'h0000);
    tick();
    rst = 1'b0;
    $display("reset released");

    // Reset in the middle of a CPU read drops it
    cpu_if.cpu_we   = 1'b0;
    cpu_if.cpu_addr = 16'h1234;
    cpu_if.cpu_req  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_val("midrst_ack", 32'(cpu_if.cpu_ack), 32'h0);
    check_val("midrst_we", 32'(vram_we), 32'h0);
    check_val("midrst_color", 32'(disp_color), 32'h00);
    check_val("midrst_addr", 32'(vram_addr), 32'h0000);
    cpu_if.cpu_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_val("midrst_no_ack", 32'(ack_count), 32'd0);
    $display("mid-read reset done");

    // Scan-out of a preloaded pixel
    disp_h   = 8'd5;
    disp_v   = 8'd3;
    disp_vis = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("scan_edge2", 32'(disp_color), 32'h00);
    @(posedge clk);
    @(negedge clk);
    check_val("scan_edge3", 32'(disp_color), 32'hA7);
    tick();
    $display("scan-out pixel (3,5)");

    // Blanking: no fetch, blank colour at the next edge
    disp_vis = 1'b0;
    disp_h   = 8'd6;
    @(posedge clk);
    @(negedge clk);
    check_val("blank_color", 32'(disp_color), 32'h00);
    check_val("blank_addr1", 32'(vram_addr), 32'h0305);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("blank_addr3", 32'(vram_addr), 32'h0305);
    tick();
    $display("blanking");

    // Back to visible at (3,6)
    disp_vis = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("unblank_color", 32'(disp_color), 32'(ref_mem[16'h0306]));
    tick();

    // CPU write with stable display
    ref_mem[16'h0102] = 8'h5C;
    cpu_if.cpu_we    = 1'b1;
    cpu_if.cpu_addr  = 16'h0102;
    cpu_if.cpu_wdata = 8'h5C;
    cpu_if.cpu_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("wr_we", 32'(vram_we), 32'h1);
    check_val("wr_addr", 32'(vram_addr), 32'h0102);
    check_val("wr_wdata", 32'(vram_wdata), 32'h5C);
    check_val("wr_ack", 32'(cpu_if.cpu_ack), 32'h1);
    tick();
    cpu_if.cpu_req = 1'b0;
    @(negedge clk);
    check_val("wr_we_pulse", 32'(vram_we), 32'h0);
    check_val("wr_ack_pulse", 32'(cpu_if.cpu_ack), 32'h0);
    check_val("wr_mem", 32'(vram_mem[16'h0102]), 32'h5C);
    tick();
    $display("cpu wr addr=0102 wdata=5c");

    // Readback
    cpu_op(1'b0, 16'h0102, 8'h00, lat, rd);
    check_val("rd_lat", 32'(lat), 32'd3);
    check_val("rd_data", 32'(rd), 32'h5C);

    // Contention: pixel change and CPU read in the same cycle
    disp_h           = 8'd7;
    cpu_if.cpu_we    = 1'b0;
    cpu_if.cpu_addr  = 16'h0102;
    cpu_if.cpu_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("cont_disp_first", 32'(vram_addr), 32'h0307);
    check_val("cont_no_ack", 32'(cpu_if.cpu_ack), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_val("cont_cpu_grant", 32'(vram_addr), 32'h0102);
    @(posedge clk);
    @(negedge clk);
    check_val("cont_color", 32'(disp_color), 32'(ref_mem[16'h0307]));
    @(posedge clk);
    @(negedge clk);
    check_val("cont_ack", 32'(cpu_if.cpu_ack), 32'h1);
    check_val("cont_rdata", 32'(cpu_if.cpu_rdata), 32'h5C);
    tick();
    cpu_if.cpu_req = 1'b0;
    $display("contention pixel (3,7) with cpu rd addr=0102");

    // Soak: abbreviated scan with random CPU traffic
    fork
      begin
        logic [7:0] exp_c;
        for (int v = 0; v < SOAK_LINES; v++) begin
          for (int h = 0; h < SOAK_LINE_LEN; h++) begin
            disp_v   = 8'(v);
            disp_h   = 8'(h);
            disp_vis = (h < SOAK_VIS_W);
            repeat (3) @(posedge clk);
            @(negedge clk);
            exp_c = disp_vis ? ref_mem[{8'(v), 8'(h)}] : 8'h00;
            check_val("soak_pixel", 32'(disp_color), 32'(exp_c));
            tick();
          end
        end
        scan_done = 1'b1;
      end
      begin
        int         s_lat;
        logic [7:0] s_rd;
        logic [7:0] s_exp;
        logic [15:0] s_addr;
        logic [7:0] s_wd;
        logic       s_we;
        while (!scan_done) begin
          repeat ($urandom_range(0, 3)) tick();
          if (!scan_done) begin
            s_we = 1'($urandom_range(0, 1));
            s_wd = 8'($urandom);
            if (s_we) begin
              // Writes stay off-screen so visible pixels keep a fixed value.
              s_addr = {1'b1, 15'($urandom)};
              ref_mem[s_addr] = s_wd;
            end else begin
              s_addr = 16'($urandom);
            end
            s_exp = ref_mem[s_addr];
            cpu_op(s_we, s_addr, s_wd, s_lat, s_rd);
            check_val("soak_ack_lat", 32'(s_lat <= 4), 32'h1);
            if (!s_we) check_val("soak_rdata", 32'(s_rd), 32'(s_exp));
          end
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
